// File: rtl/rd_ctrl_0.sv
// rd_ctrl_0: per-port egress read controller; pops the shared-memory queue, strips {src,dst,data}, one-hot decodes src.
// Latency: rd_en_out in cycle C -> out_valid in C+2 (one memory cycle + one FIFO cycle); sustains 1 word/cycle/port.
// Backpressure: out_ready low stops issue once 2 words are held or in flight; the head word holds until accepted.
// Optional feature macro RD_CTRL_DST_CHK_EN: drop words whose dst differs from the lane index, pulse dst_err, count in err_cnt.
module rd_ctrl_0 #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int WS = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            empty_in,
    output logic [N-1:0]            rd_en_out,
    input  logic [N*(2*WS+DW)-1:0]  rd_data,
    output logic [N-1:0]            out_valid,
    input  logic [N-1:0]            out_ready,
    output logic [N*DW-1:0]         out_data,
    output logic [N*WS-1:0]         out_src,
    output logic [N*N-1:0]          out_src_oh,
    output logic [N-1:0]            dst_err,
    output logic [7:0]              err_cnt
);

    localparam int WW = 2*WS + DW;   // memory word {src, dst, data}
    localparam int EW = WS + DW;     // skid FIFO entry {src, data}

`ifdef RD_CTRL_DST_CHK_EN
    // Per-lane mismatch seen on the word being captured this cycle.
    logic [N-1:0] dst_err_d;
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WW-1:0] word;
        logic [WS-1:0] word_src;
        logic [WS-1:0] word_dst;
        logic [DW-1:0] word_data;

        logic [1:0]    occ_q, occ_d;
        logic          inf_q, inf_d;
        logic          wr_ptr_q, wr_ptr_d;
        logic          rd_ptr_q, rd_ptr_d;
        logic [EW-1:0] mem_q [2];
        logic [EW-1:0] mem_d [2];

        logic          vld;
        logic          pop;
        logic          push;
        logic          rd_en;
        logic [2:0]    budget;
        logic [EW-1:0] head;
        logic [WS-1:0] head_src;
        logic [N-1:0]  head_oh;

        assign word      = rd_data[i*WW +: WW];
        assign word_src  = word[WW-1 -: WS];
        assign word_dst  = word[DW+WS-1 -: WS];
        assign word_data = word[DW-1:0];

`ifdef RD_CTRL_DST_CHK_EN
        logic dst_bad;
        // A returning word addressed to another port is dropped instead of queued.
        assign dst_bad        = inf_q && (word_dst != WS'(i));
        assign push           = inf_q && !dst_bad;
        assign dst_err_d[i]   = dst_bad;
`else
        // Without the destination check the dst field is a don't-care.
        logic dst_unused;
        assign dst_unused = ^word_dst;
        assign push       = inf_q;
`endif

        assign vld = (occ_q != 2'd0);

        // Issue only if the word still fits once everything held or in flight has landed.
        always_comb begin
            pop    = vld && out_ready[i];
            budget = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
            rd_en  = !rst && !empty_in[i] && (budget < 3'd2);
        end

        // Next state: occupancy, in-flight flag, pointers and the captured entry.
        always_comb begin
            occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
            inf_d    = rd_en;
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
            mem_d    = mem_q;
            if (push) begin
                mem_d[wr_ptr_q] = {word_src, word_data};
            end
        end

        // Lane state registers; reset drops any word still in flight.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occ_q    <= 2'd0;
                inf_q    <= 1'b0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                mem_q[0] <= '0;
                mem_q[1] <= '0;
            end else begin
                occ_q    <= occ_d;
                inf_q    <= inf_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                mem_q    <= mem_d;
            end
        end

        assign head     = mem_q[rd_ptr_q];
        assign head_src = head[EW-1 -: WS];

        // One-hot source decode; blank while the lane holds nothing or src is out of range.
        always_comb begin
            head_oh = '0;
            for (int k = 0; k < N; k++) begin
                if (vld && (head_src == WS'(k))) begin
                    head_oh[k] = 1'b1;
                end
            end
        end

        assign rd_en_out[i]              = rd_en;
        assign out_valid[i]              = vld;
        assign out_data[i*DW +: DW]      = head[DW-1:0];
        assign out_src[i*WS +: WS]       = head_src;
        assign out_src_oh[i*N +: N]      = head_oh;
    end

`ifdef RD_CTRL_DST_CHK_EN
    logic [N-1:0] dst_err_q;
    logic [7:0]   err_cnt_q, err_cnt_d;
    logic [8:0]   err_sum;

    // Add this cycle's mismatches across all lanes, clamping at 255.
    always_comb begin
        err_sum = {1'b0, err_cnt_q};
        for (int k = 0; k < N; k++) begin
            err_sum = err_sum + {8'd0, dst_err_d[k]};
        end
        err_cnt_d = (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
    end

    // Mismatch pulse and counter register together so they are visible in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_err_q <= '0;
            err_cnt_q <= 8'd0;
        end else begin
            dst_err_q <= dst_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign dst_err = dst_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign dst_err = '0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rd_ctrl_0.sv
// tb_rd_ctrl_0: scoreboard bench for rd_ctrl_0 with a queue-per-port shared-memory model.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well clear of the rising edge.
// Expected {src,data} entries are queued as the model captures them and compared at each accepted output.
module tb_rd_ctrl_0;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int WS = 2;
    localparam int WW = 2*WS + DW;
    localparam int EW = WS + DW;
    typedef logic [WW-1:0] word_t;
    typedef logic [EW-1:0] ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    empty_in;
    logic [N-1:0]    rd_en_out;
    logic [N*WW-1:0] rd_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic [N*WS-1:0] out_src;
    logic [N*N-1:0]  out_src_oh;
    logic [N-1:0]    dst_err;
    logic [7:0]      err_cnt;

    rd_ctrl_0 #(.N(N), .DW(DW), .WS(WS)) dut (
        .clk        (clk),
        .rst        (rst),
        .empty_in   (empty_in),
        .rd_en_out  (rd_en_out),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_src_oh (out_src_oh),
        .dst_err    (dst_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model and scoreboard state.
    word_t       memq [N][$];
    ent_t        expq [N][$];
    word_t       pend_w [N];
    logic [N-1:0] pend_vld;
    int          occ_m [N];
    logic [N-1:0] inf_m;
    logic [N-1:0] dst_err_m;
    int          err_m;

    // Stimulus controls.
    logic [N-1:0] rdy_drv;
    logic         rst_drv;

    // Per-port activity statistics.
    int cyc;
    int n_rden [N];
    int n_vld [N];
    int n_derr [N];
    int first_rden [N];
    int last_rden [N];
    int first_vld [N];
    int last_vld [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int p = 0; p < N; p++) begin
            n_rden[p] = 0; n_vld[p] = 0; n_derr[p] = 0;
            first_rden[p] = -1; last_rden[p] = -1;
            first_vld[p] = -1; last_vld[p] = -1;
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (pend_vld != '0) || (inf_m != '0);
        for (int p = 0; p < N; p++) begin
            if (memq[p].size() != 0 || expq[p].size() != 0 || occ_m[p] != 0) b = 1'b1;
        end
        return b;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle();
        logic [N-1:0] derr_nx;
        int           nerr;
        bit           vld_m, pop, push, rden_m;
        ent_t         e;
        logic [WS-1:0] s;
        logic [N-1:0] oh_e;

        @(negedge clk);
        cyc++;
        for (int p = 0; p < N; p++) begin
            rd_data[p*WW +: WW] = pend_vld[p] ? pend_w[p] : word_t'($urandom);
            empty_in[p] = (memq[p].size() == 0);
        end
        out_ready = rdy_drv;
        rst       = rst_drv;
        #1;
        if (rst) begin
            chk("rst_rd_en", rd_en_out, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_src", out_src, 0);
            chk("rst_oh", out_src_oh, 0);
            chk("rst_dst_err", dst_err, 0);
            chk("rst_err_cnt", err_cnt, 0);
            for (int p = 0; p < N; p++) begin
                expq[p].delete();
                occ_m[p] = 0;
            end
            inf_m = '0; pend_vld = '0; dst_err_m = '0; err_m = 0;
        end else begin
            derr_nx = '0;
            nerr    = 0;
            chk("err_cnt", err_cnt, err_m);
            chk("dst_err", dst_err, dst_err_m);
            for (int p = 0; p < N; p++) begin
                vld_m = (occ_m[p] != 0);
                chk($sformatf("valid%0d", p), out_valid[p], vld_m);
                if (vld_m && expq[p].size() != 0) begin
                    e = expq[p][0];
                    s = e[EW-1 -: WS];
                    oh_e = '0;
                    if (int'(s) < N) oh_e[s] = 1'b1;
                    chk($sformatf("data%0d", p), out_data[p*DW +: DW], e[DW-1:0]);
                    chk($sformatf("src%0d", p), out_src[p*WS +: WS], s);
                    chk($sformatf("oh%0d", p), out_src_oh[p*N +: N], oh_e);
                end
                pop    = vld_m && out_ready[p];
                rden_m = !empty_in[p] && ((occ_m[p] + int'(inf_m[p]) - int'(pop)) < 2);
                chk($sformatf("rd_en%0d", p), rd_en_out[p], rden_m);

                if (rd_en_out[p]) begin
                    n_rden[p]++; if (first_rden[p] < 0) first_rden[p] = cyc; last_rden[p] = cyc;
                end
                if (out_valid[p]) begin
                    n_vld[p]++; if (first_vld[p] < 0) first_vld[p] = cyc; last_vld[p] = cyc;
                end
                if (dst_err[p]) n_derr[p]++;

                if (pop) void'(expq[p].pop_front());
                push = inf_m[p];
`ifdef RD_CTRL_DST_CHK_EN
                if (inf_m[p] && (pend_w[p][DW+WS-1 -: WS] != WS'(p))) begin
                    push = 1'b0;
                    derr_nx[p] = 1'b1;
                    nerr++;
                end
`endif
                if (push) begin
                    assert (occ_m[p] < 2) else $error("push into full lane %0d", p);
                    expq[p].push_back({pend_w[p][WW-1 -: WS], pend_w[p][DW-1:0]});
                end
                occ_m[p] = occ_m[p] + int'(push) - int'(pop);
                inf_m[p] = rden_m;
                if (rd_en_out[p] && memq[p].size() != 0) begin
                    pend_w[p]   = memq[p].pop_front();
                    pend_vld[p] = 1'b1;
                end else begin
                    pend_vld[p] = 1'b0;
                end
            end
            dst_err_m = derr_nx;
            err_m = (err_m + nerr > 255) ? 255 : err_m + nerr;
        end
    endtask

    task automatic run_idle(input int max);
        int i;
        i = 0;
        while (busy() && i < max) begin
            cycle();
            i++;
        end
        chk("idle_timeout", busy(), 0);
    endtask

    int sum_derr;

    initial begin
        rst = 1'b1; rst_drv = 1'b1;
        empty_in = '1; out_ready = '0; rd_data = '0; rdy_drv = '0;
        pend_vld = '0; inf_m = '0; dst_err_m = '0; err_m = 0; cyc = 0;
        for (int p = 0; p < N; p++) occ_m[p] = 0;
        clear_stats();

        // Reset with queue 0 already non-empty: nothing may issue until release.
        memq[0].push_back({2'd2, 2'd0, 8'hA5});
        repeat (3) cycle();
        rst_drv = 1'b0;

        // Single read: issue in C, valid in C+2.
        cycle();
        chk("single_rd_en_c", rd_en_out[0], 1);
        cycle();
        chk("single_valid_c1", out_valid[0], 0);
        cycle();
        chk("single_valid_c2", out_valid[0], 1);
        chk("single_data", out_data[7:0], 8'hA5);
        chk("single_src", out_src[1:0], 2);
        chk("single_oh", out_src_oh[3:0], 4'b0100);
        rdy_drv = '1;
        run_idle(20);

        // Streaming: 16 words per port with out_ready held high.
        clear_stats();
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 16; k++)
                memq[p].push_back({WS'($urandom), WS'(p), DW'($urandom)});
        run_idle(100);
        for (int p = 0; p < N; p++) begin
            chk($sformatf("stream_rd_cnt%0d", p), n_rden[p], 16);
            chk($sformatf("stream_rd_span%0d", p), last_rden[p] - first_rden[p], 15);
            chk($sformatf("stream_first_vld%0d", p), first_vld[p], first_rden[p] + 2);
            chk($sformatf("stream_vld_cnt%0d", p), n_vld[p], 16);
            chk($sformatf("stream_vld_span%0d", p), last_vld[p] - first_vld[p], 15);
        end

        // Backpressure on port 1: two reads, then hold.
        clear_stats();
        rdy_drv = 4'b1101;
        for (int k = 0; k < 6; k++) memq[1].push_back({WS'(k), 2'd1, 8'h30 + 8'(k)});
        repeat (8) cycle();
        chk("bp_rd_cnt", n_rden[1], 2);
        chk("bp_valid_held", out_valid[1], 1);
        chk("bp_data_held", out_data[15:8], 8'h30);
        chk("bp_no_issue", rd_en_out[1], 0);
        rdy_drv = '1;
        cycle();
        chk("bp_release_rd_en", rd_en_out[1], 1);
        run_idle(50);

        // Reset in the cycle after a read on port 2: the returning word is lost.
        clear_stats();
        memq[2].push_back({2'd1, 2'd2, 8'h5A});
        cycle();
        chk("mid_rd_en", rd_en_out[2], 1);
        rst_drv = 1'b1;
        cycle();
        cycle();
        rst_drv = 1'b0;
        clear_stats();
        repeat (6) cycle();
        chk("mid_no_valid", n_vld[2], 0);

        // Destination mismatch on port 3.
        clear_stats();
        memq[3].push_back({2'd0, 2'd1, 8'hC3});
        repeat (6) cycle();
`ifdef RD_CTRL_DST_CHK_EN
        chk("dst_pulse", n_derr[3], 1);
        chk("dst_err_cnt", err_cnt, 1);
        chk("dst_no_valid", n_vld[3], 0);
`else
        chk("dst_pulse", n_derr[3], 0);
        chk("dst_err_cnt", err_cnt, 0);
        chk("dst_passed", n_vld[3], 1);
`endif

        // Simultaneous mismatches on every port.
        clear_stats();
        for (int p = 0; p < N; p++) memq[p].push_back({WS'(p), WS'((p + 1) % N), DW'($urandom)});
        repeat (6) cycle();
        sum_derr = 0;
        for (int p = 0; p < N; p++) sum_derr += n_derr[p];
`ifdef RD_CTRL_DST_CHK_EN
        chk("all_err_cnt", err_cnt, 5);
        chk("all_pulses", sum_derr, 4);
`else
        chk("all_err_cnt", err_cnt, 0);
        chk("all_pulses", sum_derr, 0);
`endif

        // Saturation: 300 more mismatches.
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 75; k++)
                memq[p].push_back({WS'($urandom), WS'((p + 1) % N), DW'($urandom)});
        run_idle(300);
        cycle();
`ifdef RD_CTRL_DST_CHK_EN
        chk("sat_err_cnt", err_cnt, 255);
`else
        chk("sat_err_cnt", err_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
